m_imm_decode_stage: RTL and testbench
=====================================

// Module: m_imm_decode_stage
// PURPOSE
//  Registered immediate-decode pipeline stage for the RV32/RV64 front end.
//  Classifies each fetched instruction by opcode and emits the XLEN sign-extended immediate.
//  Also emits the format one-hot, an illegal flag and the PC-relative target.
//  Sits between fetch and the register-read stage; valid/ready on both sides, 2-entry skid buffer.
// PARAMETERS
//  XLEN  32  datapath width, 32 or 64; immediates sign-extended to XLEN
//  RV64  0   1 enables OP-IMM-32 (0011011) and OP-32 (0111011) decode; must be 1 when XLEN=64
// PORTS
//  w_clk        in   1     clock, all state on rising edge
//  w_rst        in   1     synchronous active-high reset
//  w_flush      in   1     discard all buffered and incoming instructions
//  in_valid     in   1     upstream instruction valid
//  in_ready     out  1     stage can accept this cycle
//  in_ir        in   32    instruction word
//  in_pc        in   XLEN  instruction address
//  out_valid    out  1     output entry valid
//  out_ready    in   1     downstream accepts
//  out_ir       out  32    instruction word passthrough
//  out_pc       out  XLEN  PC passthrough
//  out_imm      out  XLEN  sign-extended immediate; 0 for R-type or illegal
//  out_fmt      out  5     one-hot {J,U,B,S,I}; 0 for R-type or illegal
//  out_target   out  XLEN  pc+imm for B, J, AUIPC; 0 otherwise
//  out_illegal  out  1     ir[1:0]!=2'b11 or opcode unrecognised
// BEHAVIOUR
//  Decode by opcode ir[6:0]:
//   - I: 0000011, 0010011, 1100111, 1110011, 0001111, plus 0011011 if RV64.
//   - S: 0100011.  B: 1100011.  U: 0110111, 0010111.  J: 1101111.
//   - R, no imm, not illegal: 0110011, plus 0111011 if RV64.
//   - Anything else is illegal. RV64 opcodes with RV64=0 are illegal.
//  Immediate bit layout is standard RISC-V:
//   - I = sext(ir[31:20]); S = sext(ir[31:25],ir[11:7]); B = sext(ir[31],ir[7],ir[30:25],ir[11:8],0).
//   - U = sext(ir[31:12],12'b0); J = sext(ir[31],ir[19:12],ir[20],ir[30:21],0).
//   - Sign bit is always ir[31], extended to XLEN; U-type is sign-extended above bit 31 when XLEN=64.
//  out_target = in_pc + imm, modulo 2^XLEN (wraps, no overflow flag).
//   - Applies to B, J and AUIPC (0010111) only; JALR and LUI give 0.
//  Decode is combinational on the input and captured at acceptance.
//   - Latency is 1 cycle: an input accepted at edge N is on out_* after edge N.
//  Occupancy state:
//   - EMPTY(0): out_valid=0, in_ready=1.
//   - ONE(1): out_valid=1, in_ready=1.
//   - TWO(2): out_valid=1, in_ready=0.
//   - in_ready = (count!=2), driven from registered state only, never from out_ready.
//  Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
//   - EMPTY: in_xfer -> ONE.
//   - ONE: in_xfer & !out_xfer -> TWO; out_xfer & !in_xfer -> EMPTY; both -> ONE with new entry at head.
//   - TWO: out_xfer -> ONE, skid entry moves to head; no input accepted.
//  Ordering is strict FIFO; an entry is never dropped or duplicated.
//  out_* stay stable while out_valid & !out_ready.
//  w_flush (registered effect) -> count=0 next edge.
//   - Any in_xfer in the flush cycle is discarded.
//   - out_xfer in the flush cycle still counts as consumed.
//   - w_rst has priority over w_flush.
//  Reset -> count=0; out_valid=0; out_ir, out_pc, out_imm, out_target, out_fmt, out_illegal all 0; in_ready=1.
//  Reset asserted mid-stream discards all buffered entries at that edge.
//  Data in_* is don't-care when in_valid=0; out_* data is don't-care-but-stable when out_valid=0.
// TESTING
//  - Reset with XLEN=32, out_ready=1:
//    ir=32'hFFF00093 (addi x1,x0,-1) -> next cycle out_imm=32'hFFFFFFFF, out_fmt=5'b00001, out_illegal=0.
//  - XLEN=64, RV64=1, pc=64'h1000:
//    ir=32'hFE000EE3 (beq, imm -4) -> out_imm=64'hFFFFFFFFFFFFFFFC, out_fmt=5'b00100, out_target=64'h0FFC.
//  - Backpressure: out_ready=0, present 3 back-to-back instrs A,B,C
//    -> in_ready drops after A,B accepted; C held.
//    -> raise out_ready: outputs A,B,C in order, no gaps once C accepted.
//  - Simultaneous in/out at count=1 for 10 cycles -> count stays 1, throughput 1/cycle, every entry emitted once.
//  - Flush at count=2 with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed and incoming entries never appear.
//  - ir=32'h00000013 with ir[1:0] forced to 2'b00, and opcode 0111011 with RV64=0
//    -> out_illegal=1, out_fmt=0, out_imm=0, out_target=0.

Source files
------------

// File: rtl/m_imm_decode_stage.sv
// Immediate-decode pipeline stage: classifies RV32/RV64 opcodes, sign-extends the
// immediate to XLEN and computes the PC-relative target, behind a 2-entry skid buffer.
module m_imm_decode_stage #(
  parameter int XLEN = 32,
  parameter bit RV64 = 1'b0
) (
  input  logic            w_clk,
  input  logic            w_rst,
  input  logic            w_flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [4:0] FMT_I = 5'b00001;
  localparam logic [4:0] FMT_S = 5'b00010;
  localparam logic [4:0] FMT_B = 5'b00100;
  localparam logic [4:0] FMT_U = 5'b01000;
  localparam logic [4:0] FMT_J = 5'b10000;

  typedef struct packed {
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [4:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [6:0]      opcode_s;
  logic [31:0]     imm32_s;
  logic [XLEN-1:0] imm_s;
  logic [4:0]      fmt_s;
  logic            illegal_s;
  logic            use_target_s;
  entry_t          dec_s;

  logic [1:0]      count_r;
  logic [1:0]      count_nxt_s;
  logic            in_ready_r;
  logic            out_valid_r;
  entry_t          head_r;
  entry_t          skid_r;
  logic            in_xfer_s;
  logic            out_xfer_s;
  logic            load_head_dec_s;
  logic            load_head_skid_s;
  logic            load_skid_s;

  // Opcode classification and 32-bit immediate assembly; opcodes with ir[1:0]!=11 fall to default.
  always_comb begin
    opcode_s     = in_ir[6:0];
    imm32_s      = 32'd0;
    fmt_s        = 5'd0;
    illegal_s    = 1'b0;
    use_target_s = 1'b0;
    case (opcode_s)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        imm32_s = {{20{in_ir[31]}}, in_ir[31:20]};
        fmt_s   = FMT_I;
      end
      7'b0011011: begin
        if (RV64) begin
          imm32_s = {{20{in_ir[31]}}, in_ir[31:20]};
          fmt_s   = FMT_I;
        end else begin
          illegal_s = 1'b1;
        end
      end
      7'b0100011: begin
        imm32_s = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
        fmt_s   = FMT_S;
      end
      7'b1100011: begin
        imm32_s      = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
        fmt_s        = FMT_B;
        use_target_s = 1'b1;
      end
      7'b0110111: begin
        imm32_s = {in_ir[31:12], 12'd0};
        fmt_s   = FMT_U;
      end
      7'b0010111: begin
        imm32_s      = {in_ir[31:12], 12'd0};
        fmt_s        = FMT_U;
        use_target_s = 1'b1;
      end
      7'b1101111: begin
        imm32_s      = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
        fmt_s        = FMT_J;
        use_target_s = 1'b1;
      end
      7'b0110011: begin
        illegal_s = 1'b0;
      end
      7'b0111011: begin
        if (RV64) begin
          illegal_s = 1'b0;
        end else begin
          illegal_s = 1'b1;
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Widen to XLEN and form the captured entry; target wraps modulo 2^XLEN.
  always_comb begin
    imm_s          = {{(XLEN-31){imm32_s[31]}}, imm32_s[30:0]};
    dec_s.ir       = in_ir;
    dec_s.pc       = in_pc;
    dec_s.imm      = imm_s;
    dec_s.fmt      = fmt_s;
    dec_s.illegal  = illegal_s;
    if (use_target_s) begin
      dec_s.target = in_pc + imm_s;
    end else begin
      dec_s.target = {XLEN{1'b0}};
    end
  end

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Occupancy next-state and which buffer slot gets loaded this cycle.
  always_comb begin
    count_nxt_s      = count_r;
    load_head_dec_s  = 1'b0;
    load_head_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (w_flush) begin
      count_nxt_s = ST_EMPTY;
    end else begin
      case (count_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            count_nxt_s     = ST_ONE;
            load_head_dec_s = 1'b1;
          end else begin
            count_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          case ({in_xfer_s, out_xfer_s})
            2'b10: begin
              count_nxt_s = ST_TWO;
              load_skid_s = 1'b1;
            end
            2'b01: begin
              count_nxt_s = ST_EMPTY;
            end
            2'b11: begin
              count_nxt_s     = ST_ONE;
              load_head_dec_s = 1'b1;
            end
            default: begin
              count_nxt_s = ST_ONE;
            end
          endcase
        end
        ST_TWO: begin
          if (out_xfer_s) begin
            count_nxt_s      = ST_ONE;
            load_head_skid_s = 1'b1;
          end else begin
            count_nxt_s = ST_TWO;
          end
        end
        default: begin
          count_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State and buffer registers; handshake flags are registered from the next occupancy.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      count_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_r      <= '0;
      skid_r      <= '0;
    end else begin
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != ST_TWO);
      out_valid_r <= (count_nxt_s != ST_EMPTY);
      if (load_head_dec_s) begin
        head_r <= dec_s;
      end else if (load_head_skid_s) begin
        head_r <= skid_r;
      end
      if (load_skid_s) begin
        skid_r <= dec_s;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_ir      = head_r.ir;
  assign out_pc      = head_r.pc;
  assign out_imm     = head_r.imm;
  assign out_fmt     = head_r.fmt;
  assign out_target  = head_r.target;
  assign out_illegal = head_r.illegal;

endmodule

// File: tb/tb_m_imm_decode_stage.sv
// Directed bench for m_imm_decode_stage: an RV32 (RV64=0) and an RV64 instance share
// one input stream and handshake, and are compared against hand-computed values.
module tb_m_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_ir = 32'd0;
  logic [31:0] pc32 = 32'd0;
  logic [63:0] pc64 = 64'd0;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_ir, a_out_pc, a_out_imm, a_out_target;
  logic [4:0]  a_out_fmt;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_ir;
  logic [63:0] b_out_pc, b_out_imm, b_out_target;
  logic [4:0]  b_out_fmt;

  int errors = 0;
  int checks = 0;

  m_imm_decode_stage #(.XLEN(32), .RV64(1'b0)) dut32 (
    .w_clk(clk), .w_rst(rst), .w_flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ir(in_ir), .in_pc(pc32),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ir(a_out_ir), .out_pc(a_out_pc),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_target(a_out_target), .out_illegal(a_out_illegal)
  );

  m_imm_decode_stage #(.XLEN(64), .RV64(1'b1)) dut64 (
    .w_clk(clk), .w_rst(rst), .w_flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ir(in_ir), .in_pc(pc64),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ir(b_out_ir), .out_pc(b_out_pc),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_target(b_out_target), .out_illegal(b_out_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid32 got=%b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready32 got=%b exp=1", a_in_ready); end
    checks++; if ({a_out_ir, a_out_pc, a_out_imm, a_out_target} !== 128'd0) begin errors++; $display("FAIL reset_data32 got=%h %h %h %h exp=0", a_out_ir, a_out_pc, a_out_imm, a_out_target); end
    checks++; if ({a_out_fmt, a_out_illegal} !== 6'd0) begin errors++; $display("FAIL reset_fmt32 got=%b %b exp=0", a_out_fmt, a_out_illegal); end
    checks++; if ({b_out_valid, b_in_ready} !== 2'b01) begin errors++; $display("FAIL reset_hs64 got=%b%b exp=01", b_out_valid, b_in_ready); end
    checks++; if ({b_out_pc, b_out_imm, b_out_target} !== 192'd0) begin errors++; $display("FAIL reset_data64 got=%h %h %h exp=0", b_out_pc, b_out_imm, b_out_target); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; in_ir = 32'hFFF00093; pc32 = 32'h100; pc64 = 64'h100;
    tick();
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", a_out_valid); end
    checks++; if (a_out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got=%h exp=ffffffff", a_out_imm); end
    checks++; if (a_out_fmt !== 5'b00001) begin errors++; $display("FAIL addi_fmt got=%b exp=00001", a_out_fmt); end
    checks++; if (a_out_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal got=%b exp=0", a_out_illegal); end
    checks++; if (a_out_target !== 32'd0) begin errors++; $display("FAIL addi_target got=%h exp=0", a_out_target); end
    checks++; if (b_out_imm !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL addi_imm64 got=%h exp=ffffffffffffffff", b_out_imm); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_beq64();
    out_ready = 1'b1; in_valid = 1'b1; in_ir = 32'hFE000EE3; pc32 = 32'h1000; pc64 = 64'h1000;
    tick();
    in_valid = 1'b0;
    checks++; if (b_out_imm !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("FAIL beq_imm64 got=%h exp=fffffffffffffffc", b_out_imm); end
    checks++; if (b_out_fmt !== 5'b00100) begin errors++; $display("FAIL beq_fmt64 got=%b exp=00100", b_out_fmt); end
    checks++; if (b_out_target !== 64'h0FFC) begin errors++; $display("FAIL beq_target64 got=%h exp=ffc", b_out_target); end
    checks++; if (b_out_pc !== 64'h1000) begin errors++; $display("FAIL beq_pc64 got=%h exp=1000", b_out_pc); end
    checks++; if (a_out_target !== 32'h0FFC) begin errors++; $display("FAIL beq_target32 got=%h exp=ffc", a_out_target); end
    tick();
  endtask

  task automatic test_formats();
    logic [31:0] irs  [11] = '{32'h00512423, 32'h800000B7, 32'h00001097, 32'h00001097, 32'hFF9FF06F,
                               32'h004100E7, 32'h003100B3, 32'h00000010, 32'h003100BB, 32'h0011009B, 32'hFE000EE3};
    logic [31:0] pcs  [11] = '{32'h100, 32'h100, 32'h2000, 32'hFFFFF000, 32'h100,
                               32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h0};
    logic [31:0] im32 [11] = '{32'h8, 32'h80000000, 32'h1000, 32'h1000, 32'hFFFFFFF8,
                               32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC};
    logic [63:0] im64 [11] = '{64'h8, 64'hFFFFFFFF80000000, 64'h1000, 64'h1000, 64'hFFFFFFFFFFFFFFF8,
                               64'h4, 64'h0, 64'h0, 64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFC};
    logic [31:0] tg32 [11] = '{32'h0, 32'h0, 32'h3000, 32'h0, 32'hF8,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC};
    logic [63:0] tg64 [11] = '{64'h0, 64'h0, 64'h3000, 64'h100000000, 64'hF8,
                               64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC};
    logic [4:0]  fm32 [11] = '{5'b00010, 5'b01000, 5'b01000, 5'b01000, 5'b10000,
                               5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00100};
    logic [4:0]  fm64 [11] = '{5'b00010, 5'b01000, 5'b01000, 5'b01000, 5'b10000,
                               5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00100};
    logic        il32 [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        il64 [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_ir = irs[i]; pc32 = pcs[i]; pc64 = {32'd0, pcs[i]};
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_ir !== irs[i]) begin errors++; $display("FAIL fmt_pass32[%0d] got=%b %h exp=1 %h", i, a_out_valid, a_out_ir, irs[i]); end
      checks++; if (a_out_imm !== im32[i]) begin errors++; $display("FAIL fmt_imm32[%0d] got=%h exp=%h", i, a_out_imm, im32[i]); end
      checks++; if (a_out_fmt !== fm32[i]) begin errors++; $display("FAIL fmt_fmt32[%0d] got=%b exp=%b", i, a_out_fmt, fm32[i]); end
      checks++; if (a_out_target !== tg32[i]) begin errors++; $display("FAIL fmt_tgt32[%0d] got=%h exp=%h", i, a_out_target, tg32[i]); end
      checks++; if (a_out_illegal !== il32[i]) begin errors++; $display("FAIL fmt_ill32[%0d] got=%b exp=%b", i, a_out_illegal, il32[i]); end
      checks++; if (b_out_imm !== im64[i]) begin errors++; $display("FAIL fmt_imm64[%0d] got=%h exp=%h", i, b_out_imm, im64[i]); end
      checks++; if (b_out_fmt !== fm64[i]) begin errors++; $display("FAIL fmt_fmt64[%0d] got=%b exp=%b", i, b_out_fmt, fm64[i]); end
      checks++; if (b_out_target !== tg64[i]) begin errors++; $display("FAIL fmt_tgt64[%0d] got=%h exp=%h", i, b_out_target, tg64[i]); end
      checks++; if (b_out_illegal !== il64[i]) begin errors++; $display("FAIL fmt_ill64[%0d] got=%b exp=%b", i, b_out_illegal, il64[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h00100093; pc32 = 32'h0;
    tick();
    checks++; if (a_in_ready !== 1'b1 || a_out_ir !== 32'h00100093) begin errors++; $display("FAIL bp_a got=%b %h exp=1 00100093", a_in_ready, a_out_ir); end
    in_ir = 32'h00200093;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_out_ir !== 32'h00100093) begin errors++; $display("FAIL bp_full got=%b %h exp=0 00100093", a_in_ready, a_out_ir); end
    in_ir = 32'h00300093;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_imm !== 32'd1) begin errors++; $display("FAIL bp_hold got=%b %b %h exp=0 1 1", a_in_ready, a_out_valid, a_out_imm); end
    out_ready = 1'b1;
    tick();
    checks++; if (a_out_ir !== 32'h00200093 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_b got=%h %b exp=00200093 1", a_out_ir, a_in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (a_out_ir !== 32'h00300093 || a_out_valid !== 1'b1 || a_out_imm !== 32'd3) begin errors++; $display("FAIL bp_c got=%h %b %h exp=00300093 1 3", a_out_ir, a_out_valid, a_out_imm); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_ir = 32'h00000093;
    tick();
    for (int i = 1; i <= 10; i++) begin
      in_ir = (i << 20) | 32'h00000093;
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 || a_out_ir !== ((i << 20) | 32'h00000093) || a_out_imm !== i) begin
        errors++; $display("FAIL b2b[%0d] got=%b %b %h %h exp=1 1 %h %h", i, a_out_valid, a_in_ready, a_out_ir, a_out_imm, (i << 20) | 32'h00000093, i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h00100093;
    tick();
    in_ir = 32'h00200093;
    tick();
    flush = 1'b1; in_ir = 32'h00300093;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got=%b %b exp=0 1", a_out_valid, a_in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_gone got=%b exp=0", a_out_valid); end
    in_valid = 1'b1; in_ir = 32'h00400093;
    tick();
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_ir !== 32'h00400093) begin errors++; $display("FAIL flush_next got=%b %h exp=1 00400093", a_out_valid, a_out_ir); end
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h00500093; pc32 = 32'h40;
    tick();
    in_ir = 32'h00600093; rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_hs got=%b %b exp=0 1", a_out_valid, a_in_ready); end
    checks++; if (a_out_ir !== 32'd0 || a_out_pc !== 32'd0 || a_out_imm !== 32'd0) begin errors++; $display("FAIL rstmid_data got=%h %h %h exp=0", a_out_ir, a_out_pc, a_out_imm); end
    out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_gone got=%b exp=0", a_out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_beq64();
    test_formats();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
